// File: rtl/sd_pkg.sv
// Shared types and constants for the SD 4-bit data-line engine.
package sd_pkg;

  // Data-path controller states.
  typedef enum logic [3:0] {
    IDLE,
    RX_WAIT,
    RX_DATA,
    RX_CRC,
    RX_END,
    TX_START,
    TX_DATA,
    TX_CRC,
    TX_END,
    TX_STAT,
    TX_BUSY,
    DONE
  } sd_state_t;

  // CRC16-CCITT polynomial x^16+x^12+x^5+1 (leading term implicit).
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // Card write-status token meaning "data accepted".
  localparam logic [2:0] STATUS_OK = 3'b010;

  // 512-byte block carried as 4-bit nibbles.
  localparam int BLOCK_NIBBLES_DEF = 1024;

  // One serial CRC16 step: shift left, fold in feedback when MSB xor data is set.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC16 accumulator, one instance per DAT line.
module crc16_serial
  import sd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_din,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // Clear to zero on reset or a new transfer; otherwise fold in one bit per enable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_crc <= 16'h0000;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_din);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_data.sv
// SD 4-bit DAT engine: receives or transmits one block with per-line CRC16,
// handles the write status token and busy phase, with a wait-state timeout.
// isd_en is a one-cycle tick strobe; DAT is sampled and updated only on ticks.
// odone is a one-cycle pulse; ocrc_fail is meaningful from odone until the next start.
module sd_data
  import sd_pkg::*;
#(
  parameter int          BLOCK_NIBBLES = BLOCK_NIBBLES_DEF,
  parameter logic [15:0] TIMEOUT_TICKS = 16'hFFFF
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       isd_en,
  input  logic [3:0] idata_sd,
  output logic [3:0] odata_sd,
  output logic       odata_oe,
  input  logic       istart_read,
  input  logic       istart_write,
  output logic [9:0] oaddr,
  output logic [3:0] owdata,
  output logic       owrite_en,
  input  logic [3:0] irdata,
  output logic       odone,
  output logic       ocrc_fail,
  output logic       obusy,
  output sd_state_t  odbg_state
);

  localparam logic [15:0] LP_LAST_NIB = 16'(BLOCK_NIBBLES - 1);
  localparam logic [15:0] LP_TMO_LAST = TIMEOUT_TICKS - 16'd1;

  sd_state_t   r_state, w_state_next;
  logic [15:0] r_cnt, r_tmo;
  logic [9:0]  r_addr;
  logic [3:0]  r_wdata, r_dout;
  logic        r_wen, r_oe, r_fail;
  logic [2:0]  r_stat;

  logic        w_start, w_tmo_hit, w_tmo_fail, w_last_nib, w_last_bit, w_crc_en;
  logic [3:0]  w_crc_din, w_rx_bit, w_tx_bit, w_crc_msb, w_idx_rx, w_idx_tx;
  logic [2:0]  w_status;
  logic [15:0] w_crc [4];

  assign w_start    = (r_state == IDLE) && (istart_read || istart_write);
  assign w_tmo_hit  = isd_en && (r_tmo == LP_TMO_LAST);
  assign w_last_nib = (r_cnt == LP_LAST_NIB);
  assign w_last_bit = (r_cnt[3:0] == 4'd15);
  assign w_idx_rx   = 4'd15 - r_cnt[3:0];
  assign w_idx_tx   = 4'd14 - r_cnt[3:0];
  assign w_status   = {r_stat[1:0], idata_sd[0]};

  // CRC covers data nibbles only: received nibbles in RX, RAM nibbles as they are launched in TX.
  assign w_crc_din = (r_state == RX_DATA) ? idata_sd : irdata;
  assign w_crc_en  = isd_en && ((r_state == RX_DATA) || (r_state == TX_START) ||
                                ((r_state == TX_DATA) && !w_last_nib));

  for (genvar g = 0; g < 4; g++) begin : g_line
    crc16_serial u_crc (
      .i_clk (iclk),
      .i_rst (irst),
      .i_clr (w_start),
      .i_en  (w_crc_en),
      .i_din (w_crc_din[g]),
      .o_crc (w_crc[g])
    );
    assign w_rx_bit[g]  = w_crc[g][w_idx_rx];
    assign w_tx_bit[g]  = w_crc[g][w_idx_tx];
    assign w_crc_msb[g] = w_crc[g][15];
  end

  // State register.
  always_ff @(posedge iclk) begin
    if (irst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic; wait states also flag a timeout when they give up.
  always_comb begin
    w_state_next = r_state;
    w_tmo_fail   = 1'b0;
    case (r_state)
      IDLE: begin
        if (istart_read)       w_state_next = RX_WAIT;
        else if (istart_write) w_state_next = TX_START;
      end
      RX_WAIT: begin
        if (isd_en && (idata_sd == 4'h0)) w_state_next = RX_DATA;
        else if (w_tmo_hit) begin w_state_next = DONE; w_tmo_fail = 1'b1; end
      end
      RX_DATA:  if (isd_en && w_last_nib) w_state_next = RX_CRC;
      RX_CRC:   if (isd_en && w_last_bit) w_state_next = RX_END;
      RX_END:   if (isd_en) w_state_next = DONE;
      TX_START: if (isd_en) w_state_next = TX_DATA;
      TX_DATA:  if (isd_en && w_last_nib) w_state_next = TX_CRC;
      TX_CRC:   if (isd_en && w_last_bit) w_state_next = TX_END;
      TX_END:   if (isd_en) w_state_next = TX_STAT;
      TX_STAT: begin
        if (isd_en && (r_cnt == 16'd3)) w_state_next = TX_BUSY;
        else if (w_tmo_hit) begin w_state_next = DONE; w_tmo_fail = 1'b1; end
      end
      TX_BUSY: begin
        if (isd_en && idata_sd[0]) w_state_next = DONE;
        else if (w_tmo_hit) begin w_state_next = DONE; w_tmo_fail = 1'b1; end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: counters, RAM port, DAT drivers and error flag.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_cnt   <= 16'd0;
      r_tmo   <= 16'd0;
      r_addr  <= 10'd0;
      r_wdata <= 4'h0;
      r_wen   <= 1'b0;
      r_dout  <= 4'hF;
      r_oe    <= 1'b0;
      r_fail  <= 1'b0;
      r_stat  <= 3'b000;
    end else begin
      r_wen <= 1'b0;
      // The write pulse is shown at the current address; step past it afterwards.
      if (r_wen) r_addr <= r_addr + 10'd1;
      // Counters restart on every state change; the status wait holds until its start bit.
      if (w_state_next != r_state) begin
        r_cnt <= 16'd0;
        r_tmo <= 16'd0;
      end else if (isd_en) begin
        r_tmo <= r_tmo + 16'd1;
        if ((r_state != TX_STAT) || (r_cnt != 16'd0) || !idata_sd[0]) r_cnt <= r_cnt + 16'd1;
      end
      case (r_state)
        IDLE: if (w_start) begin
          r_addr <= 10'd0;
          r_fail <= 1'b0;
          if (!istart_read) begin
            r_oe   <= 1'b1;
            r_dout <= 4'h0;
          end
        end
        RX_DATA: if (isd_en) begin
          r_wen   <= 1'b1;
          r_wdata <= idata_sd;
        end
        RX_CRC: if (isd_en && (idata_sd != w_rx_bit)) r_fail <= 1'b1;
        RX_END: if (isd_en && (idata_sd != 4'hF)) r_fail <= 1'b1;
        TX_START: if (isd_en) begin
          r_dout <= irdata;
          r_addr <= r_addr + 10'd1;
        end
        TX_DATA: if (isd_en) begin
          if (w_last_nib) begin
            r_dout <= w_crc_msb;
          end else begin
            r_dout <= irdata;
            r_addr <= r_addr + 10'd1;
          end
        end
        TX_CRC: if (isd_en) r_dout <= w_last_bit ? 4'hF : w_tx_bit;
        TX_END: if (isd_en) begin
          r_oe   <= 1'b0;
          r_dout <= 4'hF;
        end
        TX_STAT: if (isd_en && (r_cnt != 16'd0)) begin
          r_stat <= w_status;
          if ((r_cnt == 16'd3) && (w_status != STATUS_OK)) r_fail <= 1'b1;
        end
        default: ;
      endcase
      if (w_tmo_fail) r_fail <= 1'b1;
    end
  end

  // Reset releases DAT combinationally so an abort frees the bus in the same cycle.
  assign odata_oe   = r_oe & ~irst;
  assign odata_sd   = odata_oe ? r_dout : 4'hF;
  assign oaddr      = r_addr;
  assign owdata     = r_wdata;
  assign owrite_en  = r_wen;
  assign odone      = (r_state == DONE);
  assign ocrc_fail  = r_fail;
  assign obusy      = (r_state != IDLE);
  assign odbg_state = r_state;

endmodule

// File: doc/sd_data.md
SD_DATA -- requirements
Module: sd_data

Interface
REQ-001 SHALL have parameter BLOCK_NIBBLES, default 1024, nibbles per data block (512 bytes).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 16'hFFFF, maximum SD-clock ticks spent in any wait state.
REQ-003 SHALL have port iclk, input, 1, system clock (36 MHz); one clock domain; reset is synchronous and active-high.
REQ-004 SHALL have port irst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port isd_en, input, 1, one-cycle strobe marking an SD clock tick; strobes are at least 2 iclk apart.
REQ-006 SHALL have ports idata_sd input 4 (DAT[3:0] sampled), odata_sd output 4 (DAT driven) and odata_oe output 1 (DAT driver enable).
REQ-007 SHALL have ports istart_read input 1 and istart_write input 1, one-cycle start pulses.
REQ-008 SHALL have ports oaddr output 10 (RAM nibble address), owdata output 4, owrite_en output 1 (received-data RAM) and irdata input 4 (transmit RAM, valid 1 iclk after oaddr).
REQ-009 SHALL have ports odone output 1 (one-cycle completion pulse), ocrc_fail output 1 (error flag, valid with odone) and obusy output 1 (high when not IDLE).

Function
REQ-010 SHALL implement the FSM states IDLE, RX_WAIT, RX_DATA, RX_CRC, RX_END, TX_START, TX_DATA, TX_CRC, TX_END, TX_STAT, TX_BUSY and DONE.
REQ-011 SHALL go IDLE->RX_WAIT on istart_read and IDLE->TX_START on istart_write; read wins on simultaneous starts; starts outside IDLE SHALL be ignored.
REQ-012 SHALL advance state, counters and CRC only on iclk edges with isd_en=1, except the IDLE and DONE exits, which are immediate.
REQ-013 SHALL, in RX_WAIT, enter RX_DATA on the first tick with idata_sd==4'h0.
REQ-014 SHALL, in RX_DATA, on each tick drive owdata=idata_sd with owrite_en high for exactly one iclk at the current oaddr, then increment oaddr; after BLOCK_NIBBLES nibbles it SHALL enter RX_CRC.
REQ-015 SHALL compute four independent CRC16s (poly x^16+x^12+x^5+1, init 0, one per line), shifting over the data bits only.
REQ-016 SHALL, in RX_CRC, shift in 16 received bits per line MSB first and set a mismatch flag if any line differs from its computed CRC.
REQ-017 SHALL, in RX_END, require idata_sd==4'hF, set ocrc_fail if not, and then enter DONE.
REQ-018 SHALL, in TX_START, drive odata_oe=1 and odata_sd=4'h0 for one tick, then enter TX_DATA.
REQ-019 SHALL, in TX_DATA, drive odata_sd=irdata per tick and advance oaddr on the tick, so new data is valid before the next tick; after BLOCK_NIBBLES nibbles it SHALL enter TX_CRC.
REQ-020 SHALL, in TX_CRC, drive 16 CRC bits per line MSB first, then drive 4'hF in TX_END for one tick, then set odata_oe=0.
REQ-021 SHALL, in TX_STAT, wait for DAT0=0, sample the next 3 DAT0 bits, and set ocrc_fail unless they equal 3'b010; it SHALL then enter TX_BUSY.
REQ-022 SHALL, in TX_BUSY, wait until DAT0=1, then enter DONE.
REQ-023 SHALL reset the timeout counter on entry to RX_WAIT, TX_STAT and TX_BUSY; if the counter reaches TIMEOUT_TICKS it SHALL set ocrc_fail and enter DONE.
REQ-024 SHALL, in DONE, pulse odone for one iclk, hold ocrc_fail until the next start, and return to IDLE.
REQ-025 SHALL reset oaddr to 0 on every start.
REQ-026 SHALL make oaddr wrap from 1023 to 0 without a flag.
REQ-027 SHALL hold odata_sd at 4'hF whenever odata_oe=0.

Reset
REQ-028 SHALL, on irst, enter IDLE with odata_oe=0, odata_sd=4'hF, oaddr=0, owdata=0, owrite_en=0, odone=0, ocrc_fail=0, obusy=0, CRCs=0 and counters=0.
REQ-029 SHALL abort any transfer when irst is asserted mid-operation, release DAT within the same cycle, and not pulse odone.

Structure
REQ-030 SHALL place the shared package sd_pkg, holding the FSM state enum, CRC16 polynomial 16'h1021, STATUS_OK 3'b010 and BLOCK_NIBBLES default.
REQ-031 SHALL use one sub-module, crc16_serial (1-bit serial CRC16 with enable and clear), instantiated four times.

Verification
REQ-032 SHALL verify: read of 1024 zero nibbles followed by CRC 0x0000 per line and end 4'hF -> 1024 owrite_en pulses, addresses 0..1023, odone=1, ocrc_fail=0.
REQ-033 SHALL verify: same read with DAT2 CRC bit 5 flipped -> odone=1, ocrc_fail=1.
REQ-034 SHALL verify: write of RAM pattern nibble=addr[3:0] with status 3'b010 and a 20-tick busy -> DAT shows start 0, 1024 nibbles, per-line CRCs equal to a reference model, then end F; odone after busy release; ocrc_fail=0.
REQ-035 SHALL verify: write with status 3'b101 -> ocrc_fail=1.
REQ-036 SHALL verify: read with no start bit and TIMEOUT_TICKS=100 -> odone on tick 100, ocrc_fail=1.
REQ-037 SHALL verify: irst at nibble 500 of a write -> odata_oe=0 the next cycle, obusy=0, no odone, and the next istart_read restarts from oaddr=0.
